// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell stepped over WIDTH
// cycles, LSB first, with a start/busy/done handshake and registered result.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic             fa_s, fa_co;
   logic [WIDTH-1:0] acc_sh;

   // The single full-adder cell shared by every bit position
   always_comb begin
      fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      fa_co = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q)
            | (b_sh_q[0] & carry_q);
   end

   always_comb begin
      acc_sh = acc_q >> 1;
      acc_sh[WIDTH-1] = fa_s;
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            carry_d = fa_co;
            acc_d   = acc_sh;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // Last bit: publish the fully shifted word and the MSB carry
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = acc_sh;
               cout_d  = fa_co;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == ADD);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance and a 1-bit instance.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one 8-bit addition and observe it; the callers judge the results
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, output int lat, output int bcyc,
                       output int overlap, output logic [7:0] s,
                       output logic c, output logic d_after);
      a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = -1; bcyc = 0; overlap = 0;
      for (int e = 0; e <= 20; e++) begin
         if (busy8) bcyc++;
         if (busy8 && done8) overlap++;
         if (done8) begin
            lat = e;
            break;
         end
         tick();
      end
      s = sum8;
      c = cout8;
      tick();
      d_after = done8;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (busy8 !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%b exp=0", busy8);
      end
      checks++;
      if (done8 !== 1'b0) begin
         failures++; $display("FAIL reset_done got=%b exp=0", done8);
      end
      checks++;
      if (sum8 !== 8'h00) begin
         failures++; $display("FAIL reset_sum got=%h exp=00", sum8);
      end
      checks++;
      if (cout8 !== 1'b0) begin
         failures++; $display("FAIL reset_cout got=%b exp=0", cout8);
      end
      checks++;
      if ({busy1, done1, sum1, cout1} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_w1 got=%b exp=0000", {busy1, done1, sum1, cout1});
      end
   endtask

   task automatic test_basic();
      int lat, bcyc, ov;
      logic [7:0] s;
      logic c, d;
      run8(8'h5A, 8'h3C, 1'b0, lat, bcyc, ov, s, c, d);
      checks++;
      if (lat !== 8) begin
         failures++; $display("FAIL basic_latency got=%0d exp=8", lat);
      end
      checks++;
      if (bcyc !== 8) begin
         failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcyc);
      end
      checks++;
      if (ov !== 0) begin
         failures++; $display("FAIL basic_busy_done_overlap got=%0d exp=0", ov);
      end
      checks++;
      if ({c, s} !== 9'h096) begin
         failures++; $display("FAIL basic_sum got=%b_%h exp=0_96", c, s);
      end
      checks++;
      if (d !== 1'b0) begin
         failures++; $display("FAIL basic_done_width got=%b exp=0", d);
      end
   endtask

   task automatic test_carry();
      int lat, bcyc, ov;
      logic [7:0] s;
      logic c, d;
      run8(8'hFF, 8'h01, 1'b0, lat, bcyc, ov, s, c, d);
      checks++;
      if (lat !== 8 || {c, s} !== 9'h100) begin
         failures++;
         $display("FAIL carry_ff_01 got=%b_%h lat=%0d exp=1_00 lat=8", c, s, lat);
      end
      run8(8'hFF, 8'hFF, 1'b1, lat, bcyc, ov, s, c, d);
      checks++;
      if (lat !== 8 || {c, s} !== 9'h1FF) begin
         failures++;
         $display("FAIL carry_ff_ff_1 got=%b_%h lat=%0d exp=1_ff lat=8", c, s, lat);
      end
   endtask

   task automatic test_ignored_start();
      int ndone = 0;
      int at = -1;
      logic [7:0] s = '0;
      logic c = 1'b0;
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      tick();
      for (int e = 1; e <= 14; e++) begin
         start8 = (e == 3);
         a8 = (e == 3) ? 8'hAA : 8'(e * 37);
         b8 = (e == 3) ? 8'h55 : 8'(e * 91);
         cin8 = e[0];
         tick();
         if (done8) begin
            ndone++; at = e; s = sum8; c = cout8;
         end
      end
      start8 = 1'b0;
      checks++;
      if (ndone !== 1 || at !== 8) begin
         failures++;
         $display("FAIL ignored_start_done got=%0d@%0d exp=1@8", ndone, at);
      end
      checks++;
      if ({c, s} !== 9'h030) begin
         failures++; $display("FAIL ignored_start_sum got=%b_%h exp=0_30", c, s);
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0;
      int bad = 0;
      int at[3] = '{-1, -1, -1};
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      for (int e = 0; e <= 29; e++) begin
         tick();
         if (done8) begin
            if (ndone < 3) at[ndone] = e;
            ndone++;
            if ({cout8, sum8} !== 9'h002) bad++;
         end
      end
      start8 = 1'b0;
      checks++;
      if (ndone !== 3) begin
         failures++; $display("FAIL held_start_count got=%0d exp=3", ndone);
      end
      checks++;
      if (at[0] !== 8 || at[1] !== 18 || at[2] !== 28) begin
         failures++;
         $display("FAIL held_start_edges got=%0d,%0d,%0d exp=8,18,28",
                  at[0], at[1], at[2]);
      end
      checks++;
      if (bad !== 0) begin
         failures++; $display("FAIL held_start_sum bad=%0d exp=0", bad);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      int lat, bcyc, ov;
      logic [7:0] s;
      logic c, d;
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy8, done8, cout8, sum8} !== 11'h000) begin
         failures++;
         $display("FAIL reset_mid_outputs got=busy%b done%b %b_%h exp=0 0 0_00",
                  busy8, done8, cout8, sum8);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", ndone);
      end
      run8(8'h81, 8'h80, 1'b0, lat, bcyc, ov, s, c, d);
      checks++;
      if (lat !== 8 || {c, s} !== 9'h101) begin
         failures++;
         $display("FAIL reset_mid_restart got=%b_%h lat=%0d exp=1_01 lat=8", c, s, lat);
      end
   endtask

   task automatic test_width1();
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         failures++;
         $display("FAIL w1_busy got=busy%b done%b exp=1 0", busy1, done1);
      end
      tick();
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL w1_done got=busy%b done%b exp=0 1", busy1, done1);
      end
      checks++;
      if ({cout1, sum1} !== 2'b11) begin
         failures++; $display("FAIL w1_sum got=%b%b exp=11", cout1, sum1);
      end
      tick();
      checks++;
      if (done1 !== 1'b0) begin
         failures++; $display("FAIL w1_done_pulse got=%b exp=0", done1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_width1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
